// File: rtl/serial_receiver.sv
// serial_receiver: receive-only UART for the 9600-baud serial link.
// The serial_rx pin is synchronised into the clock domain. Each bit is sampled
// at its centre. Every good byte appears as a one-cycle rx_data_valid pulse.
//
// Optional feature macro: SERIAL_RECEIVER_PARITY_EN
//   undefined (default): 8N1 frames.
//   defined            : 8E1 frames. A bad even-parity bit is reported on
//                        rx_framing_error instead of rx_data_valid.
module serial_receiver #(
  parameter int CYCLES_PER_BIT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_framing_error,
  output logic       rx_busy
);

  // Width of the per-bit cycle counter.
  localparam int CNT_W = $clog2(CYCLES_PER_BIT);

  // Count values at which the line is sampled.
  // HALF_LAST is the centre of the start bit, measured from the falling edge.
  // FULL_LAST is one whole bit later, which lands on the next bit centre.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYCLES_PER_BIT - 1);

  localparam logic [2:0] WAIT_IDLE = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
`ifdef SERIAL_RECEIVER_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd5;
`endif

  // Synchroniser flops. They reset to the idle (high) line level, so reset
  // release never looks like a falling edge.
  logic rx_meta_reg;
  logic rx_s;

  // Frame state.
  logic [2:0]       state_reg,   state_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg,   shift_next;

  // Output registers.
  logic [7:0]       data_reg,    data_next;
  logic             valid_reg,   valid_next;
  logic             err_reg,     err_next;

`ifdef SERIAL_RECEIVER_PARITY_EN
  // Set when the sampled parity bit disagrees with even parity of the byte.
  logic             par_err_reg, par_err_next;
`endif

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= serial_rx;
      rx_s        <= rx_meta_reg;
    end
  end

  // Next-state logic: bit timing, data shifting and frame verdict.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
    par_err_next = par_err_reg;
`endif

    case (state_reg)
      // After reset or a framing error, wait for a high line.
      // This stops a held-low line or a break from being read as a start bit.
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      // Wait for the falling edge of a start bit.
      IDLE: begin
        if (!rx_s) begin
          state_next   = START;
          cnt_next     = '0;
          bit_cnt_next = 3'd0;
        end
      end

      // Recheck the line at the centre of the start bit.
      // A high level here means the low pulse was a glitch, so drop it.
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      // Shift in eight data bits, LSB first.
      // Each new bit enters at bit 7, so bit 0 holds the first bit received.
      DATA: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

`ifdef SERIAL_RECEIVER_PARITY_EN
      // Sample the even-parity bit. Any odd count of ones across the byte
      // and the parity bit means the frame is bad.
      PARITY: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next     = '0;
          par_err_next = ^{shift_reg, rx_s};
          state_next   = STOP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`endif

      // Judge the frame at the centre of the stop bit.
      // Returning to IDLE here, half a bit early, lets a back-to-back start
      // edge be caught.
      STOP: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next = '0;
          if (!rx_s) begin
            err_next   = 1'b1;
            state_next = WAIT_IDLE;
`ifdef SERIAL_RECEIVER_PARITY_EN
          end else if (par_err_reg) begin
            err_next   = 1'b1;
            state_next = IDLE;
`endif
          end else begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = WAIT_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Register the frame state and outputs.
  // Reset aborts any frame in progress without producing a pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= WAIT_IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'h00;
      data_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
      par_err_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
`ifdef SERIAL_RECEIVER_PARITY_EN
      par_err_reg <= par_err_next;
`endif
    end
  end

  assign rx_data          = data_reg;
  assign rx_data_valid    = valid_reg;
  assign rx_framing_error = err_reg;
  assign rx_busy          = (state_reg != WAIT_IDLE) && (state_reg != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// Testbench for serial_receiver with CYCLES_PER_BIT = 16.
// The bench drives whole UART frames onto the line. A reference function
// decides from the frame contents whether each frame should give a valid
// byte or a framing error.
// Honours SERIAL_RECEIVER_PARITY_EN the same way as the design.
module tb_serial_receiver;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       serial_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_framing_error;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  // Pulse monitor state.
  int         valid_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] last_valid_data = 8'h00;
  bit         both_seen = 1'b0;

  // Reference state: the last byte that should have been accepted.
  logic [7:0] model_data = 8'h00;

  serial_receiver #(.CYCLES_PER_BIT(CPB)) dut (
    .clock            (clock),
    .reset            (reset),
    .serial_rx        (serial_rx),
    .rx_data          (rx_data),
    .rx_data_valid    (rx_data_valid),
    .rx_framing_error (rx_framing_error),
    .rx_busy          (rx_busy)
  );

  always #5 clock = ~clock;

  // Count output pulses, sampled on the falling edge.
  always @(negedge clock) begin
    if (rx_data_valid) begin
      valid_cnt       = valid_cnt + 1;
      last_valid_data = rx_data;
    end
    if (rx_framing_error) err_cnt = err_cnt + 1;
    if (rx_data_valid && rx_framing_error) both_seen = 1'b1;
  end

  // Hard limit on total simulation time.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit exceeded");
    $fatal(1, "timeout");
  end

  // Expected verdict: does this frame deliver a byte?
  function automatic bit frame_ok(input logic [7:0] d, input bit stop_bit, input bit par_bit);
    bit ok;
    ok = stop_bit;
`ifdef SERIAL_RECEIVER_PARITY_EN
    // Even parity: the data ones plus the parity bit must total an even number.
    if (((d[0] + d[1] + d[2] + d[3] + d[4] + d[5] + d[6] + d[7] + par_bit) % 2) != 0) ok = 1'b0;
`else
    if (par_bit && 1'b0) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input bit b);
    serial_rx = b;
    idle_cycles(CPB);
  endtask

  // Send one full frame. The line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SERIAL_RECEIVER_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
  endtask

  function automatic bit even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Send a frame and compare the pulses it produced against the reference.
  task automatic send_and_check(input string name, input logic [7:0] d, input bit stop_bit,
                                input bit par_bit);
    int v0, e0;
    bit ok;
    v0 = valid_cnt;
    e0 = err_cnt;
    ok = frame_ok(d, stop_bit, par_bit);
    send_frame(d, stop_bit, par_bit);
    if (ok) model_data = d;
    checks++;
    if ((valid_cnt - v0) != (ok ? 1 : 0)) begin
      errors++;
      $display("FAIL %s valid_pulses: got %0d expected %0d (byte %02h)", name, valid_cnt - v0, ok ? 1 : 0, d);
    end
    checks++;
    if ((err_cnt - e0) != (ok ? 0 : 1)) begin
      errors++;
      $display("FAIL %s error_pulses: got %0d expected %0d (byte %02h)", name, err_cnt - e0, ok ? 0 : 1, d);
    end
    checks++;
    if (rx_data !== model_data) begin
      errors++;
      $display("FAIL %s rx_data: got %02h expected %02h", name, rx_data, model_data);
    end
    $display("frame %s byte=%02h stop=%0b par=%0b -> valid=%0d err=%0d rx_data=%02h",
             name, d, stop_bit, par_bit, valid_cnt - v0, err_cnt - e0, rx_data);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    serial_rx = 1'b1;
    idle_cycles(4);
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %02h expected 00", rx_data); end
    checks++;
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_data_valid); end
    checks++;
    if (rx_framing_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", rx_framing_error); end
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    reset = 1'b0;
    idle_cycles(CPB);
    $display("reset: rx_data=%02h valid=%b err=%b busy=%b", rx_data, rx_data_valid, rx_framing_error, rx_busy);
  endtask

  task automatic test_basic();
    send_and_check("basic_A5", 8'hA5, 1'b1, even_par(8'hA5));
    idle_cycles(CPB);
    checks++;
    if (last_valid_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_pulse_data: got %02h expected a5", last_valid_data);
    end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    serial_rx = 1'b0;
    idle_cycles(4);
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", rx_busy); end
    serial_rx = 1'b1;
    idle_cycles(12);
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0", rx_busy); end
    idle_cycles(2 * CPB);
    checks++;
    if ((valid_cnt != v0) || (err_cnt != e0)) begin
      errors++;
      $display("FAIL glitch_pulses: got valid=%0d err=%0d expected 0 0", valid_cnt - v0, err_cnt - e0);
    end
    $display("glitch: valid=%0d err=%0d busy=%b", valid_cnt - v0, err_cnt - e0, rx_busy);
  endtask

  task automatic test_framing_error();
    send_and_check("stop_low_3C", 8'h3C, 1'b0, even_par(8'h3C));
    idle_cycles(3 * CPB);
    serial_rx = 1'b1;
    idle_cycles(2 * CPB);
    send_and_check("after_err_81", 8'h81, 1'b1, even_par(8'h81));
  endtask

  task automatic test_reset_midframe();
    int v0, e0;
    logic [7:0] d;
    d = 8'h5A;
    v0 = valid_cnt;
    e0 = err_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    serial_rx = d[4];
    idle_cycles(CPB / 2);
    reset = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    serial_rx = 1'b1;
    idle_cycles(4 * CPB);
    checks++;
    if ((valid_cnt != v0) || (err_cnt != e0)) begin
      errors++;
      $display("FAIL abort_pulses: got valid=%0d err=%0d expected 0 0", valid_cnt - v0, err_cnt - e0);
    end
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", rx_busy); end
    // The reset also clears the held byte.
    model_data = 8'h00;
    $display("abort: valid=%0d err=%0d busy=%b", valid_cnt - v0, err_cnt - e0, rx_busy);
    send_and_check("after_reset_5A", 8'h5A, 1'b1, even_par(8'h5A));
  endtask

  task automatic test_back_to_back();
    send_and_check("b2b_00", 8'h00, 1'b1, even_par(8'h00));
    send_and_check("b2b_FF", 8'hFF, 1'b1, even_par(8'hFF));
    serial_rx = 1'b1;
    idle_cycles(CPB);
  endtask

`ifdef SERIAL_RECEIVER_PARITY_EN
  task automatic test_parity();
    send_and_check("par_bad_01", 8'h01, 1'b1, 1'b0);
    idle_cycles(CPB);
    send_and_check("par_good_01", 8'h01, 1'b1, 1'b1);
    idle_cycles(CPB);
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    bit stop_bit, par_bit;
    int gap;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      stop_bit = ($urandom_range(0, 5) != 0);
      par_bit = even_par(d) ^ ($urandom_range(0, 4) == 0);
      send_and_check("random", d, stop_bit, par_bit);
      // After a low stop bit, the line must go high for a few cycles so the
      // receiver can rearm.
      gap = stop_bit ? $urandom_range(0, 20) : $urandom_range(4, 20);
      serial_rx = 1'b1;
      idle_cycles(gap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing_error();
    test_reset_midframe();
    test_back_to_back();
`ifdef SERIAL_RECEIVER_PARITY_EN
    test_parity();
`endif
    test_random();
    idle_cycles(CPB);
    checks++;
    if (both_seen) begin
      errors++;
      $display("FAIL exclusive_pulses: got valid and error together, expected never");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
